// File: rtl/iir_stream_src_if.sv
// Bundle between the IIR sample source and whoever loads it and consumes its stream:
// FIFO push port, coefficient config port, playback control and the filter-side outputs.
interface iir_stream_src_if #(
  parameter int NB = 12
);
  logic          wr_en;
  logic [NB-1:0] wr_data;
  logic          full;
  logic          ovf;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [NB-1:0] cfg_data;
  logic [3:0]    gap;
  logic          start;
  logic [NB-1:0] dout;
  logic          vout;
  logic [NB-1:0] a1;
  logic [NB-1:0] a2;
  logic [NB-1:0] b0;
  logic [NB-1:0] b1;
  logic [NB-1:0] b2;
  logic          busy;
  logic          end_sim;

  // Controller side: loads samples/coefficients, starts playback, observes the stream.
  modport master (
    output wr_en, wr_data, cfg_we, cfg_addr, cfg_data, gap, start,
    input  full, ovf, dout, vout, a1, a2, b0, b1, b2, busy, end_sim
  );

  // Source side: the iir_stream_src block itself.
  modport slave (
    input  wr_en, wr_data, cfg_we, cfg_addr, cfg_data, gap, start,
    output full, ovf, dout, vout, a1, a2, b0, b1, b2, busy, end_sim
  );
endinterface

// File: rtl/iir_stream_src.sv
// Synthesizable stimulus source for the IIR filter: preloaded sample FIFO played out on
// DOUT/VOUT with a programmable gap, coefficient registers, and an end-of-run flag after a drain period.
module iir_stream_src #(
  parameter int NB        = 12,
  parameter int AW        = 4,
  parameter int DRAIN_CYC = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  iir_stream_src_if.slave bus
);

  localparam int DEPTH = 2 ** AW;
  localparam int DW    = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  logic [NB-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  state_e        state_q,     state_d;
  logic [3:0]    gcnt_load_q, gcnt_load_d;
  logic [3:0]    gcnt_q,      gcnt_d;
  logic [DW-1:0] dcnt_q,      dcnt_d;
  logic [NB-1:0] dout_q,      dout_d;
  logic          vout_q,      vout_d;
  logic          busy_q,      busy_d;
  logic          end_sim_q,   end_sim_d;
  logic [NB-1:0] a1_q, a2_q, b0_q, b1_q, b2_q;

  assign full_s = (count_q == (AW + 1)'(DEPTH));
  assign push_s = bus.wr_en & ~full_s;

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_s && !pop_s) begin
        count_q <= count_q + 1'b1;
      end else if (pop_s && !push_s) begin
        count_q <= count_q - 1'b1;
      end
      if (bus.wr_en && full_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FIFO storage; emptiness is tracked by count_q so the array itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Playback FSM next state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    gcnt_load_d = gcnt_load_q;
    gcnt_d      = gcnt_q;
    dcnt_d      = dcnt_q;
    dout_d      = dout_q;
    vout_d      = 1'b0;
    end_sim_d   = 1'b0;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_SEND;
          gcnt_load_d = bus.gap;
        end else begin
          end_sim_d = (state_q == ST_DONE);
        end
      end
      ST_SEND: begin
        // Only SEND looks at emptiness, so late pushes still stream while in GAP.
        if (count_q != '0) begin
          pop_s  = 1'b1;
          dout_d = mem_q[rd_ptr_q];
          vout_d = 1'b1;
          if (gcnt_load_q == 4'd0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_GAP;
            gcnt_d  = gcnt_load_q;
          end
        end else begin
          state_d = ST_DRAIN;
          dcnt_d  = DW'(DRAIN_CYC - 1);
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q - 4'd1;
        if (gcnt_q == 4'd1) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SEND) || (state_d == ST_GAP) || (state_d == ST_DRAIN);
  end

  // FSM state, counters and stream outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      gcnt_load_q <= 4'd0;
      gcnt_q      <= 4'd0;
      dcnt_q      <= '0;
      dout_q      <= '0;
      vout_q      <= 1'b0;
      busy_q      <= 1'b0;
      end_sim_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_load_q <= gcnt_load_d;
      gcnt_q      <= gcnt_d;
      dcnt_q      <= dcnt_d;
      dout_q      <= dout_d;
      vout_q      <= vout_d;
      busy_q      <= busy_d;
      end_sim_q   <= end_sim_d;
    end
  end

  // Coefficient registers, frozen while a run is in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a1_q <= '0;
      a2_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else if (bus.cfg_we && !busy_q) begin
      case (bus.cfg_addr)
        3'd0:    a1_q <= bus.cfg_data;
        3'd1:    a2_q <= bus.cfg_data;
        3'd2:    b0_q <= bus.cfg_data;
        3'd3:    b1_q <= bus.cfg_data;
        3'd4:    b2_q <= bus.cfg_data;
        default: ;
      endcase
    end
  end

  assign bus.full    = full_s;
  assign bus.ovf     = ovf_q;
  assign bus.dout    = dout_q;
  assign bus.vout    = vout_q;
  assign bus.busy    = busy_q;
  assign bus.end_sim = end_sim_q;
  assign bus.a1      = a1_q;
  assign bus.a2      = a2_q;
  assign bus.b0      = b0_q;
  assign bus.b1      = b1_q;
  assign bus.b2      = b2_q;

endmodule

// File: tb/tb_iir_stream_src.sv
// Self-checking bench for iir_stream_src: randomized samples/coefficients compared cycle by
// cycle against an arithmetic model of the playback timeline.
module tb_iir_stream_src;
  localparam int NB        = 12;
  localparam int DRAIN_CYC = 8;
  localparam int MAXC      = 300;
  localparam int SW        = 3 + 6 * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iir_stream_src_if #(.NB(NB)) bus ();
  iir_stream_src #(.NB(NB), .AW(4), .DRAIN_CYC(DRAIN_CYC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [NB-1:0] exp_coef [5];
  logic [NB-1:0] mdl_dout;
  logic [SW-1:0] obs [0:MAXC];
  logic [NB-1:0] cap_push [$];
  int            cap_cfg_t = -1;
  logic [2:0]    cap_cfg_addr = 3'd0;
  logic [NB-1:0] cap_cfg_data = '0;

  // {vout, dout, end_sim, busy, a1, a2, b0, b1, b2}
  function automatic logic [SW-1:0] snap();
    return {bus.vout, bus.dout, bus.end_sim, bus.busy, bus.a1, bus.a2, bus.b0, bus.b1, bus.b2};
  endfunction

  // Cycle after the START edge at which END_SIM is first seen high.
  function automatic int end_time(int n, int g);
    return 1 + n * (g + 1) + DRAIN_CYC + 1;
  endfunction

  // Expected outputs t cycles after the START edge: sample i is valid at t = 1 + i*(g+1).
  function automatic logic [SW-1:0] model_at(int t, int n, int g, logic [NB-1:0] smp [$],
                                              logic [NB-1:0] prev);
    int            k;
    logic          v;
    logic [NB-1:0] d;
    k = (t < 1) ? 0 : ((t - 1) / (g + 1) + 1);
    if (k > n) k = n;
    v = (t >= 1) && (((t - 1) % (g + 1)) == 0) && (((t - 1) / (g + 1)) < n);
    d = (k > 0) ? smp[k-1] : prev;
    return {v, d, (t >= end_time(n, g)), (t < end_time(n, g) - 1),
            exp_coef[0], exp_coef[1], exp_coef[2], exp_coef[3], exp_coef[4]};
  endfunction

  task automatic push_vals(input logic [NB-1:0] vals [$]);
    foreach (vals[i]) begin
      bus.wr_en = 1'b1;
      bus.wr_data = vals[i];
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [NB-1:0] data);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (addr < 3'd5) exp_coef[addr] = data;
  endtask

  // Pulse START, optionally push/config during the run, record outputs for t = 0..ncyc.
  task automatic start_and_capture(input logic [3:0] g, input int ncyc);
    bus.gap = g;
    for (int t = 0; t <= ncyc; t++) begin
      bus.start = (t == 0);
      if (t >= 1 && t <= cap_push.size()) begin
        bus.wr_en = 1'b1;
        bus.wr_data = cap_push[t-1];
      end else begin
        bus.wr_en = 1'b0;
      end
      bus.cfg_we = (t == cap_cfg_t);
      bus.cfg_addr = cap_cfg_addr;
      bus.cfg_data = cap_cfg_data;
      @(posedge clk); #1;
      obs[t] = snap();
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.cfg_we = 1'b0;
    cap_push.delete();
    cap_cfg_t = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (exp_coef[i]) exp_coef[i] = '0;
    mdl_dout = '0;
    n_cmp++; if (bus.vout !== 1'b0) begin n_fail++; $display("FAIL reset_vout got=%b exp=0", bus.vout); end
    n_cmp++; if (bus.dout !== '0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
    n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.end_sim !== 1'b0) begin n_fail++; $display("FAIL reset_end_sim got=%b exp=0", bus.end_sim); end
    n_cmp++;
    if ({bus.a1, bus.a2, bus.b0, bus.b1, bus.b2} !== '0) begin
      n_fail++; $display("FAIL reset_coef got=%h exp=0", {bus.a1, bus.a2, bus.b0, bus.b1, bus.b2});
    end
  endtask

  task automatic test_empty_start();
    logic [NB-1:0] smp [$];
    logic [SW-1:0] e;
    int et;
    et = end_time(0, 0);
    start_and_capture(4'(($urandom_range(15, 0))), et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 0, 0, smp, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL empty_start t=%0d got=%h exp=%h", t, obs[t], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] smp [$];
    logic [SW-1:0] e;
    int et;
    smp = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
    push_vals(smp);
    cfg_write(3'd0, 12'h123);
    cfg_write(3'd4, 12'hF00);
    cfg_write(3'd2, NB'($urandom));
    et = end_time(5, 0);
    start_and_capture(4'd0, et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 5, 0, smp, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL back_to_back t=%0d got=%h exp=%h", t, obs[t], e); end
    end
    mdl_dout = smp[4];
  endtask

  task automatic test_gap();
    logic [NB-1:0] smp [$];
    logic [SW-1:0] e;
    int et;
    smp = '{12'h7FF, 12'h800, 12'hABC};
    push_vals(smp);
    cfg_write(3'd1, NB'($urandom));
    cfg_write(3'(($urandom_range(7, 5))), NB'($urandom));
    cap_cfg_t = 4;
    cap_cfg_addr = 3'd1;
    cap_cfg_data = ~exp_coef[1];
    et = end_time(3, 3);
    start_and_capture(4'd3, et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 3, 3, smp, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL gap t=%0d got=%h exp=%h", t, obs[t], e); end
    end
    mdl_dout = smp[2];
  endtask

  task automatic test_full_wrap();
    logic [NB-1:0] smp [$];
    logic [NB-1:0] more [$];
    logic [SW-1:0] e;
    int et;
    for (int i = 0; i < 17; i++) smp.push_back(NB'($urandom));
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = smp[i];
      @(posedge clk); #1;
      n_cmp++; if (bus.full !== (i >= 15)) begin n_fail++; $display("FAIL full_flag i=%0d got=%b exp=%b", i, bus.full, (i >= 15)); end
      n_cmp++; if (bus.ovf !== (i == 16)) begin n_fail++; $display("FAIL ovf_flag i=%0d got=%b exp=%b", i, bus.ovf, (i == 16)); end
    end
    bus.wr_en = 1'b0;
    void'(smp.pop_back());
    et = end_time(16, 0);
    start_and_capture(4'd0, et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 16, 0, smp, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL full_play t=%0d got=%h exp=%h", t, obs[t], e); end
    end
    mdl_dout = smp[15];
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus.ovf); end
    for (int i = 0; i < 3; i++) more.push_back(NB'($urandom));
    push_vals(more);
    n_cmp++; if (bus.end_sim !== 1'b1) begin n_fail++; $display("FAIL done_hold got=%b exp=1", bus.end_sim); end
    et = end_time(3, 0);
    start_and_capture(4'd0, et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 3, 0, more, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL wrap_play t=%0d got=%h exp=%h", t, obs[t], e); end
    end
    mdl_dout = more[2];
  endtask

  task automatic test_stream_and_reset();
    logic [NB-1:0] pre [$];
    logic [NB-1:0] smp [$];
    logic [SW-1:0] e;
    int et;
    for (int i = 0; i < 2; i++) pre.push_back(NB'($urandom));
    push_vals(pre);
    smp = pre;
    for (int i = 0; i < 10; i++) begin
      cap_push.push_back(NB'($urandom));
      smp.push_back(cap_push[i]);
    end
    et = end_time(12, 0);
    start_and_capture(4'd0, et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 12, 0, smp, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL push_pop t=%0d got=%h exp=%h", t, obs[t], e); end
    end
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back(NB'($urandom));
    push_vals(smp);
    bus.gap = 4'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.vout !== 1'b1 || bus.dout !== smp[2]) begin
      n_fail++; $display("FAIL mid_stream got=%b/%h exp=1/%h", bus.vout, bus.dout, smp[2]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (exp_coef[i]) exp_coef[i] = '0;
    mdl_dout = '0;
    n_cmp++; if (bus.vout !== 1'b0) begin n_fail++; $display("FAIL rst_vout got=%b exp=0", bus.vout); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf); end
    smp.delete();
    et = end_time(0, 0);
    start_and_capture(4'd0, et + 2);
    for (int t = 0; t <= et + 2; t++) begin
      e = model_at(t, 0, 0, smp, mdl_dout);
      n_cmp++;
      if (obs[t] !== e) begin n_fail++; $display("FAIL post_rst t=%0d got=%h exp=%h", t, obs[t], e); end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] smp [$];
    logic [SW-1:0] e;
    int n;
    int g;
    int et;
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < 3; c++) cfg_write(3'(($urandom_range(7, 0))), NB'($urandom));
      n = $urandom_range(16, 0);
      g = $urandom_range(15, 0);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(NB'($urandom));
      push_vals(smp);
      et = end_time(n, g);
      start_and_capture(4'(g), et + 2);
      for (int t = 0; t <= et + 2; t++) begin
        e = model_at(t, n, g, smp, mdl_dout);
        n_cmp++;
        if (obs[t] !== e) begin n_fail++; $display("FAIL random it=%0d n=%0d g=%0d t=%0d got=%h exp=%h", it, n, g, t, obs[t], e); end
      end
      if (n > 0) mdl_dout = smp[n-1];
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = 3'd0;
    bus.cfg_data = '0;
    bus.gap = 4'd0;
    bus.start = 1'b0;
    test_reset();
    test_empty_start();
    test_back_to_back();
    test_gap();
    test_full_wrap();
    test_stream_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
